// File: rtl/rx_frame_controller.sv
module rx_frame_controller #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_BITS       = 128,
  parameter int unsigned BANK_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            num_bits,
  output logic                  det_rst,
  input  logic                  det_dat,
  input  logic                  det_vld,
  input  logic                  det_found,
  input  logic [BANK_WIDTH-1:0] det_bank,
  output logic [MAX_BITS-1:0]   frame_data,
  output logic [7:0]            frame_len,
  output logic [BANK_WIDTH-1:0] frame_bank,
  output logic                  frame_vld,
  output logic                  timeout,
  output logic                  busy
);

  // One shared timer serves guard, preamble search and inter-bit gap.
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN      = 8'(MAX_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GUARD,
    S_SEARCH,
    S_COLLECT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            nbits_q, nbits_d;
  logic [MAX_BITS-1:0]   data_q, data_d;
  logic [7:0]            len_q, len_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= '0;
      data_q    <= '0;
      len_q     <= '0;
      bank_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      nbits_q   <= nbits_d;
      data_q    <= data_d;
      len_q     <= len_d;
      bank_q    <= bank_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    nbits_d   = nbits_q;
    data_d    = data_q;
    len_d     = len_q;
    bank_d    = bank_q;
    timeout_d = 1'b0;

    // Abort overrides every other transition, including a completing bit.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_GUARD;
            cnt_d   = '0;
            if (num_bits == 8'd0)        nbits_d = 8'd1;
            else if (num_bits > MAX_LEN) nbits_d = MAX_LEN;
            else                         nbits_d = num_bits;
          end
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = S_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SEARCH: begin
          if (det_found) begin
            state_d   = S_COLLECT;
            cnt_d     = '0;
            bank_d    = det_bank;
            data_d    = '0;
            bit_cnt_d = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_COLLECT: begin
          if (det_vld) begin
            data_d    = {data_q[MAX_BITS-2:0], det_dat};
            bit_cnt_d = bit_cnt_q + 8'd1;
            cnt_d     = '0;
            if ((bit_cnt_q + 8'd1) == nbits_q) begin
              state_d = S_DONE;
              len_d   = bit_cnt_q + 8'd1;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign det_rst    = !((state_q == S_SEARCH) || (state_q == S_COLLECT));
  assign busy       = (state_q != S_IDLE);
  assign frame_vld  = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign frame_data = data_q;
  assign frame_len  = len_q;
  assign frame_bank = bank_q;

endmodule

// File: doc/rx_frame_controller.md
RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

Interface
REQ-001 Parameter GUARD_CYCLES, default 16: detector hold-off after start, in clk cycles (>=1).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: max wait for preamble, and max gap between bits in COLLECT (>=2).
REQ-003 Parameter MAX_BITS, default 128: frame buffer width (2..255).
REQ-004 Parameter BANK_WIDTH, default 4: width of detector frequency bank index.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to open a receive window.
REQ-008 abort  input  1  synchronous cancel of the current window.
REQ-009 num_bits  input  8  expected payload bits after preamble; sampled with start.
REQ-010 det_rst  output  1  reset to preamble detector; 1 = detector held in reset.
REQ-011 det_dat  input  1  detector payload bit.
REQ-012 det_vld  input  1  det_dat qualifier.
REQ-013 det_found  input  1  detector preamble_detected level.
REQ-014 det_bank  input  BANK_WIDTH  detector frequency_bank.
REQ-015 frame_data  output  MAX_BITS  collected payload, first bit in frame_data[frame_len-1], last in bit 0, unused upper bits 0.
REQ-016 frame_len  output  8  bits in frame_data.
REQ-017 frame_bank  output  BANK_WIDTH  det_bank latched at preamble detection.
REQ-018 frame_vld  output  1  one-cycle pulse, frame complete.
REQ-019 timeout  output  1  one-cycle pulse, window failed.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 States IDLE, GUARD, SEARCH, COLLECT, DONE; encoding free.
REQ-022 IDLE: det_rst=1; start -> GUARD; num_bits latched, 0 treated as 1, >MAX_BITS clamped to MAX_BITS.
REQ-023 start outside IDLE ignored, no side effects.
REQ-024 GUARD: det_rst=1 for exactly GUARD_CYCLES cycles, then SEARCH.
REQ-025 SEARCH: det_rst=0; cycle timer from 0; det_found=1 -> COLLECT next cycle, det_bank latched into frame_bank, frame_data cleared, bit count 0.
REQ-026 SEARCH timer reaching TIMEOUT_CYCLES-1 with det_found=0 -> timeout=1 next cycle, state IDLE.
REQ-027 det_found and timer expiry same cycle: det_found wins, no timeout.
REQ-028 COLLECT: det_rst=0; each det_vld=1 shifts det_dat into frame_data bit 0 (left shift), count+1; det_vld=0 cycles leave data unchanged.
REQ-029 COLLECT: det_found changes ignored; det_vld outside COLLECT ignored.
REQ-030 COLLECT: accepted bit bringing count to latched num_bits -> DONE next cycle; further det_vld ignored.
REQ-031 COLLECT gap timer reset on each det_vld; TIMEOUT_CYCLES consecutive cycles without det_vld -> timeout pulse, IDLE, frame_vld not asserted; last-bit det_vld on expiry cycle wins.
REQ-032 DONE: one cycle; frame_vld=1, frame_len=count; then IDLE. Latency final det_vld to frame_vld = 1 cycle.
REQ-033 frame_data, frame_len, frame_bank hold from frame_vld until next SEARCH->COLLECT transition.
REQ-034 abort=1 in any non-IDLE state -> IDLE next cycle, no frame_vld, no timeout; abort beats all other transitions incl. completion; abort in IDLE has no effect.
REQ-035 frame_vld and timeout never high together; each at most once per start.
REQ-036 Counters sized to hold TIMEOUT_CYCLES and GUARD_CYCLES without wrap.

Reset
REQ-037 rst_n=0 forces immediately: state IDLE, det_rst=1, busy=0, frame_vld=0, timeout=0, frame_data=0, frame_len=0, frame_bank=0, all counters 0.
REQ-038 Reset mid-window discards partial frame; first start after release behaves per REQ-022.

Verification
REQ-039 Normal: GUARD_CYCLES=16, start, num_bits=5, det_found 40 cycles later with det_bank=3, bits 1,0,1,1,0 -> frame_vld one cycle after 5th bit, frame_data[4:0]=10110, frame_len=5, frame_bank=3; det_rst=1 exactly 16 cycles after start.
REQ-040 No preamble: TIMEOUT_CYCLES=64, start, det_found never -> timeout pulse 16+64 cycles after start, busy low next cycle, frame_vld never.
REQ-041 Stalled payload: num_bits=8, only 3 det_vld then silence -> timeout TIMEOUT_CYCLES after 3rd bit; frame_* outputs hold earlier values except frame_bank/data cleared per REQ-025.
REQ-042 Clamp/ignore: num_bits=0 -> frame after 1 bit, frame_len=1; num_bits=200 with MAX_BITS=128 -> frame_len=128; second start during COLLECT ignored.
REQ-043 Abort and reset: abort same cycle as final det_vld -> no frame_vld, IDLE; rst_n low mid-COLLECT -> all outputs at REQ-037 values within same cycle.
REQ-044 Race: det_found on last SEARCH timer cycle -> COLLECT, no timeout.
